bram_stream_fifo: RTL and testbench

- Single-clock, BRAM-backed stream FIFO with valid/ready on both sides.
- Read latency of the storage array is configurable (1-3 cycles).
- A small prefetch/skid output buffer hides that latency, so a continuously ready consumer sees one word per cycle.
- Used between UDP/IP pipeline stages as packet/payload buffering; carries a tlast-style sideband alongside the data.

---
 rtl/bram_stream_fifo.sv | 118 +++++++++++
 tb/tb_bram_stream_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_fifo.sv
// rtl/bram_stream_fifo.sv - BRAM-backed valid/ready stream FIFO with a latency-hiding output buffer
// Array reads run ahead on a credit basis so returning data always has a free output-buffer slot.
module bram_stream_fifo #(
  parameter  int DATA_WIDTH        = 64,
  parameter  int DATA_DEPTH        = 512,
  parameter  int BRAM_LATENCY      = 2,
  parameter  int ALMOST_FULL_LEVEL = DATA_DEPTH - 8,
  localparam int OUT_DEPTH         = BRAM_LATENCY + 2,
  localparam int LEVEL_WIDTH       = $clog2(DATA_DEPTH + OUT_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_last,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   almost_full,
  output logic                   empty
);
  localparam int AW  = $clog2(DATA_DEPTH);
  localparam int ACW = AW + 1;
  localparam int IFW = $clog2(BRAM_LATENCY + 1);
  localparam int OBW = $clog2(OUT_DEPTH + 1);
  localparam int OPW = $clog2(OUT_DEPTH);
  localparam logic [ACW-1:0]         DEPTH_C = ACW'(DATA_DEPTH);
  localparam logic [LEVEL_WIDTH-1:0] AF_C    = LEVEL_WIDTH'(ALMOST_FULL_LEVEL);
  localparam logic [OPW-1:0]         OB_LAST = OPW'(OUT_DEPTH - 1);

  if (BRAM_LATENCY < 1 || BRAM_LATENCY > 3) begin : g_bad_latency
    $error("bram_stream_fifo: BRAM_LATENCY must be 1, 2 or 3");
  end
  if (DATA_DEPTH < 4 || (DATA_DEPTH & (DATA_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bram_stream_fifo: DATA_DEPTH must be a power of two >= 4");
  end

  logic [DATA_WIDTH:0]      mem [DATA_DEPTH];
  logic [DATA_WIDTH:0]      rdata_q [BRAM_LATENCY];
  logic [DATA_WIDTH:0]      ob_q [OUT_DEPTH];
  logic [DATA_WIDTH:0]      ob_d [OUT_DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ACW-1:0]           array_count_q, array_count_d;
  logic [BRAM_LATENCY-1:0]  vld_q, vld_d;
  logic [OPW-1:0]           ob_wr_q, ob_wr_d, ob_rd_q, ob_rd_d;
  logic [OBW-1:0]           ob_count_q, ob_count_d;
  logic [LEVEL_WIDTH-1:0]   level_q, level_d;
  logic                     s_ready_q, s_ready_d;
  logic [IFW-1:0]           in_flight, in_flight_d;
  logic                     wr_en, pop, issue, ret_valid;

  // s_ready is held low for the whole reset window, not just after the first edge
  assign s_ready     = s_ready_q & ~rst;
  assign m_valid     = (ob_count_q != '0);
  assign m_data      = ob_q[ob_rd_q][DATA_WIDTH-1:0];
  assign m_last      = ob_q[ob_rd_q][DATA_WIDTH];
  assign level       = level_q;
  assign almost_full = (level_q >= AF_C);
  assign empty       = (level_q == '0);
  assign wr_en       = s_valid & s_ready;
  assign pop         = m_valid & m_ready;
  assign ret_valid   = vld_q[BRAM_LATENCY-1];

  always_comb begin
    in_flight   = '0;
    in_flight_d = '0;
    ob_d        = ob_q;
    for (int i = 0; i < BRAM_LATENCY; i++) in_flight = in_flight + IFW'(vld_q[i]);
    issue = (array_count_q != '0) &&
            ((int'(in_flight) + int'(ob_count_q) - int'(pop)) < OUT_DEPTH);
    wr_ptr_d      = wr_ptr_q + AW'(wr_en);
    rd_ptr_d      = rd_ptr_q + AW'(issue);
    array_count_d = array_count_q + ACW'(wr_en) - ACW'(issue);
    vld_d         = (vld_q << 1) | BRAM_LATENCY'(issue);
    for (int i = 0; i < BRAM_LATENCY; i++) in_flight_d = in_flight_d + IFW'(vld_d[i]);
    if (ret_valid) ob_d[ob_wr_q] = rdata_q[BRAM_LATENCY-1];
    ob_wr_d    = ret_valid ? ((ob_wr_q == OB_LAST) ? '0 : ob_wr_q + 1'b1) : ob_wr_q;
    ob_rd_d    = pop ? ((ob_rd_q == OB_LAST) ? '0 : ob_rd_q + 1'b1) : ob_rd_q;
    ob_count_d = ob_count_q + OBW'(ret_valid) - OBW'(pop);
    level_d    = LEVEL_WIDTH'(array_count_d) + LEVEL_WIDTH'(in_flight_d) + LEVEL_WIDTH'(ob_count_d);
    s_ready_d  = (array_count_d < DEPTH_C);
  end

  // Storage and read pipeline carry no reset; vld_q alone decides what is real
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {s_last, s_data};
    rdata_q[0] <= mem[rd_ptr_q];
    for (int i = 1; i < BRAM_LATENCY; i++) rdata_q[i] <= rdata_q[i-1];
    ob_q <= ob_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      array_count_q <= '0;
      vld_q         <= '0;
      ob_wr_q       <= '0;
      ob_rd_q       <= '0;
      ob_count_q    <= '0;
      level_q       <= '0;
      s_ready_q     <= 1'b1;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      array_count_q <= array_count_d;
      vld_q         <= vld_d;
      ob_wr_q       <= ob_wr_d;
      ob_rd_q       <= ob_rd_d;
      ob_count_q    <= ob_count_d;
      level_q       <= level_d;
      s_ready_q     <= s_ready_d;
    end
  end
endmodule

// File: tb/tb_bram_stream_fifo.sv
// tb/tb_bram_stream_fifo.sv - three-latency bench for bram_stream_fifo
// Each instance is tracked by a credit-level model; the L=2 instance also gets directed literal checks.
module tb_bram_stream_fifo;
  localparam int DW    = 64;
  localparam int DEPTH = 512;
  localparam int RING  = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b0;
  int            cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_lat
    localparam int L   = g + 1;
    localparam int OUT = L + 2;
    localparam int LW  = $clog2(DEPTH + OUT + 1);
    logic          s_ready, m_valid, m_last, almost_full, empty;
    logic [DW-1:0] m_data;
    logic [LW-1:0] level;

    bram_stream_fifo #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .BRAM_LATENCY(L)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_last(s_last), .s_valid(s_valid),
      .s_ready(s_ready), .m_data(m_data), .m_last(m_last), .m_valid(m_valid),
      .m_ready(m_ready), .level(level), .almost_full(almost_full), .empty(empty)
    );

    int          chk = 0, bad = 0;
    int          n_acc = 0, n_iss = 0, n_pop = 0, lvl;
    int          iss_cyc [RING];
    logic [DW:0] words [$];
    logic        prev_rst = 1'b0, exp_sr, exp_mv, pop_now, acc_now;

    task automatic cmp(input string nm, input logic [DW:0] act, input logic [DW:0] exp);
      chk++;
      if (act !== exp) begin
        bad++;
        $display("FAIL L%0d %s @%0d: got %0h expected %0h", L, nm, cyc, act, exp);
      end
    endtask

    // Word k issues once accepted, one per cycle, while fewer than OUT words are issued-but-unpopped
    always @(negedge clk) begin
      if (rst) begin
        if (prev_rst) begin
          cmp("m_valid_rst", m_valid, 0);
          cmp("level_rst", level, 0);
          cmp("empty_rst", empty, 1);
          cmp("af_rst", almost_full, 0);
        end
        cmp("s_ready_rst", s_ready, 0);
        n_acc = 0; n_iss = 0; n_pop = 0;
        words.delete();
      end else begin
        exp_sr = (n_acc - n_iss) < DEPTH;
        exp_mv = (n_pop < n_iss) && (iss_cyc[n_pop % RING] + L + 1 <= cyc);
        lvl    = n_acc - n_pop;
        cmp("s_ready", s_ready, exp_sr);
        cmp("m_valid", m_valid, exp_mv);
        cmp("level", level, lvl);
        cmp("empty", empty, lvl == 0);
        cmp("almost_full", almost_full, lvl >= DEPTH - 8);
        if (exp_mv) begin
          cmp("m_data", m_data, words[0][DW-1:0]);
          cmp("m_last", m_last, words[0][DW]);
        end
        pop_now = exp_mv && m_ready;
        acc_now = s_valid && exp_sr;
        if (pop_now) begin
          n_pop++;
          void'(words.pop_front());
        end
        if (n_iss < n_acc && (n_iss - n_pop) < OUT) begin
          iss_cyc[n_iss % RING] = cyc;
          n_iss++;
        end
        if (acc_now) begin
          words.push_back({s_last, s_data});
          n_acc++;
        end
      end
      prev_rst = rst;
    end
  end

  int chk_m = 0, bad_m = 0;

  task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
    chk_m++;
    if (act !== exp) begin
      bad_m++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One word into an idle FIFO with m_ready high; first m_valid must land at t+2+BRAM_LATENCY
  task automatic latency_probe(input string nm, input logic [DW-1:0] d, input logic l);
    int t, rise;
    s_valid = 1'b1; s_data = d; s_last = l; m_ready = 1'b1;
    @(negedge clk);
    t = cyc;
    check({nm, "_accept"}, g_lat[1].s_ready, 1);
    rise = -1;
    for (int k = 0; k < 20 && rise < 0; k++) begin
      step();
      s_valid = 1'b0;
      @(negedge clk);
      if (cyc == t + 1) check({nm, "_level1"}, g_lat[1].level, 1);
      if (g_lat[1].m_valid) begin
        rise = cyc;
        check({nm, "_data"}, g_lat[1].m_data, d);
        check({nm, "_last"}, g_lat[1].m_last, l);
      end
    end
    check({nm, "_rise_cycle"}, rise - t, 4);
    step();
    @(negedge clk);
    check({nm, "_level0"}, g_lat[1].level, 0);
    check({nm, "_empty"}, g_lat[1].empty, 1);
    step();
  endtask

  initial begin
    int nxt, n_out, gaps, maxl, ord, acc, af_lvl, stab;
    logic [DW-1:0] prev_d;
    logic prev_hold;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_level", g_lat[1].level, 0);
    check("reset_empty", g_lat[1].empty, 1);
    check("reset_m_valid", g_lat[1].m_valid, 0);
    check("reset_s_ready", g_lat[1].s_ready, 1);
    check("reset_af", g_lat[1].almost_full, 0);
    step();

    latency_probe("single", 64'hA5A5_0001, 1'b1);

    nxt = 0; n_out = 0; gaps = 0; maxl = 0; ord = 0;
    m_ready = 1'b1;
    for (int k = 0; k < 3000 && n_out < 1000; k++) begin
      s_data = DW'(nxt); s_last = (nxt % 100 == 99); s_valid = (nxt < 1000);
      @(negedge clk);
      if (int'(g_lat[1].level) > maxl) maxl = int'(g_lat[1].level);
      if (g_lat[1].m_valid) begin
        if (g_lat[1].m_data != DW'(n_out)) ord++;
        n_out++;
      end else if (n_out > 0) gaps++;
      if (s_valid && g_lat[1].s_ready) nxt++;
      step();
    end
    check("stream_count", n_out, 1000);
    check("stream_order_errors", ord, 0);
    check("stream_gaps", gaps, 0);
    check("stream_level_bound", maxl <= 5, 1);

    s_valid = 1'b0;
    repeat (10) step();
    acc = 0; af_lvl = -1;
    m_ready = 1'b0;
    for (int k = 0; k < 600; k++) begin
      s_valid = 1'b1; s_data = DW'(5000 + acc); s_last = acc[0];
      @(negedge clk);
      if (g_lat[1].almost_full && af_lvl < 0) af_lvl = int'(g_lat[1].level);
      if (g_lat[1].s_ready) acc++;
      step();
    end
    check("fill_accepted", acc, DEPTH + 4);
    check("fill_af_level", af_lvl, DEPTH - 8);
    @(negedge clk);
    check("fill_level", g_lat[1].level, DEPTH + 4);
    check("fill_s_ready", g_lat[1].s_ready, 0);
    step();

    s_valid = 1'b0; m_ready = 1'b1;
    n_out = 0; ord = 0;
    for (int k = 0; k < 1000 && n_out < DEPTH + 4; k++) begin
      @(negedge clk);
      if (g_lat[1].m_valid) begin
        if (g_lat[1].m_data != DW'(5000 + n_out)) ord++;
        n_out++;
      end
      step();
    end
    check("drain_count", n_out, DEPTH + 4);
    check("drain_order_errors", ord, 0);
    repeat (10) step();
    @(negedge clk);
    check("drain_empty", g_lat[1].empty, 1);
    step();

    stab = 0; prev_hold = 1'b0; prev_d = '0;
    for (int k = 0; k < 20000; k++) begin
      s_valid = 1'($urandom % 2); m_ready = 1'($urandom % 2);
      s_data = {$urandom, $urandom}; s_last = 1'($urandom % 2);
      @(negedge clk);
      if (prev_hold && (!g_lat[1].m_valid || g_lat[1].m_data != prev_d)) stab++;
      prev_hold = g_lat[1].m_valid && !m_ready;
      prev_d = g_lat[1].m_data;
      step();
    end
    check("random_head_stable", stab, 0);

    s_valid = 1'b1; m_ready = 1'b0;
    for (int k = 0; k < 100; k++) begin
      s_data = DW'(9000 + k); s_last = 1'b0;
      step();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check("pre_reset_held", g_lat[1].level > 90, 1);
    step();
    rst = 1'b1; s_valid = 1'b1;
    step();
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    check("post_reset_m_valid", g_lat[1].m_valid, 0);
    check("post_reset_level", g_lat[1].level, 0);
    check("post_reset_empty", g_lat[1].empty, 1);
    step();
    latency_probe("fresh", 64'h0000_BEEF, 1'b0);
    repeat (10) step();

    $display("%0d/%0d checks passed",
             (chk_m - bad_m) + (g_lat[0].chk - g_lat[0].bad) +
             (g_lat[1].chk - g_lat[1].bad) + (g_lat[2].chk - g_lat[2].bad),
             chk_m + g_lat[0].chk + g_lat[1].chk + g_lat[2].chk);
    $finish;
  end
endmodule
